// File: rtl/matmul_pkg.sv
// Shared types and constants for the iterative matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_M      = 5;
    localparam int unsigned DEF_K      = 2;
    localparam int unsigned DEF_N      = 3;
    localparam int unsigned DEF_W      = 15;
    localparam bit          DEF_SIGNED = 1'b0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned v);
        return (clog2(v) > 0) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate: acc_out = acc_in + ext(a*b), modulo 2^RW.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned RW     = 2 * DEF_W + 1,
    parameter bit          SIGNED = DEF_SIGNED
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [RW-1:0] acc_in,
    output logic [RW-1:0] acc_out
);

    logic [2*W-1:0] prod_c;
    logic [RW-1:0]  prod_rw_c;

    // Low 2W bits of the product of the pre-extended operands is exact in both modes.
    always_comb begin
        if (SIGNED) prod_c = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        else        prod_c = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    generate
        if (RW > 2 * W) begin : g_ext
            assign prod_rw_c = SIGNED ? {{(RW - 2 * W){prod_c[2*W-1]}}, prod_c}
                                      : {{(RW - 2 * W){1'b0}}, prod_c};
        end else begin : g_trunc
            assign prod_rw_c = prod_c[RW-1:0];
        end
    endgenerate

    assign acc_out = acc_in + prod_rw_c;

endmodule

// File: rtl/matrix_mult_iterative.sv
// Sequential R = A x B using one shared MAC per clock; Busy/Finished handshake.
module matrix_mult_iterative
    import matmul_pkg::*;
#(
    parameter int unsigned M      = DEF_M,
    parameter int unsigned K      = DEF_K,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned W      = DEF_W,
    parameter int unsigned RW     = 2 * W + clog2(K),
    parameter bit          SIGNED = DEF_SIGNED
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [M*K*W-1:0]    MatrixA,
    input  logic [K*N*W-1:0]    MatrixB,
    output logic [M*N*RW-1:0]   MatrixResult,
    output logic                Busy,
    output logic                Finished
);

    localparam int unsigned IW   = cnt_w(M);
    localparam int unsigned JW   = cnt_w(N);
    localparam int unsigned KW   = cnt_w(K);
    localparam int unsigned AW   = M * K * W;
    localparam int unsigned BW   = K * N * W;
    localparam int unsigned RESW = M * N * RW;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q;
    logic [JW-1:0]   j_q;
    logic [KW-1:0]   k_q;
    logic [RW-1:0]   acc_q, acc_next_c;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [RESW-1:0] res_q, res_upd_c;
    logic [W-1:0]    a_elem_c, b_elem_c;
    logic            k_last_c, j_last_c, i_last_c, accept_c, run_last_c;
    int unsigned     a_sh_c, b_sh_c, r_sh_c;

    assign k_last_c   = (k_q == KW'(K - 1));
    assign j_last_c   = (j_q == JW'(N - 1));
    assign i_last_c   = (i_q == IW'(M - 1));
    assign run_last_c = i_last_c && j_last_c && k_last_c;
    assign accept_c   = Start && (state_q != ST_RUN);

    // Element selection by shifting the MSB-first packed arrays.
    always_comb begin
        a_sh_c    = (M * K - 1 - (32'(i_q) * K + 32'(k_q))) * W;
        b_sh_c    = (K * N - 1 - (32'(k_q) * N + 32'(j_q))) * W;
        r_sh_c    = (M * N - 1 - (32'(i_q) * N + 32'(j_q))) * RW;
        a_elem_c  = W'(a_q >> a_sh_c);
        b_elem_c  = W'(b_q >> b_sh_c);
        res_upd_c = (res_q & ~(RESW'({RW{1'b1}}) << r_sh_c))
                  | (RESW'(acc_next_c) << r_sh_c);
    end

    matmul_mac #(
        .W      (W),
        .RW     (RW),
        .SIGNED (SIGNED)
    ) u_mac (
        .a       (a_elem_c),
        .b       (b_elem_c),
        .acc_in  (acc_q),
        .acc_out (acc_next_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (Start) state_d = ST_RUN;
            ST_RUN:           if (run_last_c) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy     = 1'b0;
        Finished = 1'b0;
        Busy     = (state_q == ST_RUN);
        Finished = (state_q == ST_DONE);
    end

    // Index sequencing, operand capture and result assembly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            MatrixResult <= '0;
        end else if (accept_c) begin
            a_q   <= MatrixA;
            b_q   <= MatrixB;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (!k_last_c) begin
                acc_q <= acc_next_c;
                k_q   <= k_q + KW'(1);
            end else begin
                res_q <= res_upd_c;
                acc_q <= '0;
                k_q   <= '0;
                if (j_last_c) begin
                    j_q <= '0;
                    i_q <= i_q + IW'(1);
                end else begin
                    j_q <= j_q + JW'(1);
                end
                if (i_last_c && j_last_c) MatrixResult <= res_upd_c;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_iterative.sv
// Bench for matrix_mult_iterative: default unsigned, signed 2x2x2 and 1x1x1 instances.
module tb_matrix_mult_iterative;

    typedef logic [1023:0] bus_t;
    typedef struct {
        string name;
        bus_t  a;
        bus_t  b;
        bus_t  r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default instance: 5x2 * 2x3, W=15, RW=31, unsigned
    logic          rst0, st0, busy0, fin0;
    logic [149:0]  a0;
    logic [89:0]   b0;
    logic [464:0]  r0;
    matrix_mult_iterative u0 (
        .Clk(clk), .Reset(rst0), .Start(st0), .MatrixA(a0), .MatrixB(b0),
        .MatrixResult(r0), .Busy(busy0), .Finished(fin0));

    // Signed 2x2 * 2x2, W=8, RW=17
    logic          rst1, st1, busy1, fin1;
    logic [31:0]   a1;
    logic [31:0]   b1;
    logic [67:0]   r1;
    matrix_mult_iterative #(.M(2), .K(2), .N(2), .W(8), .SIGNED(1'b1)) u1 (
        .Clk(clk), .Reset(rst1), .Start(st1), .MatrixA(a1), .MatrixB(b1),
        .MatrixResult(r1), .Busy(busy1), .Finished(fin1));

    // Degenerate 1x1x1, W=15, RW=30
    logic          rst2, st2, busy2, fin2;
    logic [14:0]   a2;
    logic [14:0]   b2;
    logic [29:0]   r2;
    matrix_mult_iterative #(.M(1), .K(1), .N(1)) u2 (
        .Clk(clk), .Reset(rst2), .Start(st2), .MatrixA(a2), .MatrixB(b2),
        .MatrixResult(r2), .Busy(busy2), .Finished(fin2));

    function automatic longint get_elem(input bus_t v, input int cnt, input int idx, input int w);
        bus_t t;
        t = v >> ((cnt - 1 - idx) * w);
        return longint'(t[63:0]) & longint'((64'd1 << w) - 64'd1);
    endfunction

    function automatic bus_t put_elem(input bus_t v, input int cnt, input int idx,
                                      input int w, input longint val);
        bus_t m;
        bus_t x;
        m = bus_t'((64'd1 << w) - 64'd1);
        x = bus_t'(val) & m;
        return v | (x << ((cnt - 1 - idx) * w));
    endfunction

    // Reference: integer matrix product, each entry reduced modulo 2^rw.
    function automatic bus_t ref_mult(input bus_t a, input bus_t b, input int m, input int k,
                                      input int n, input int w, input int rw, input bit sgn);
        bus_t r;
        r = '0;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                longint s;
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    longint x;
                    longint y;
                    x = get_elem(a, m * k, i * k + kk, w);
                    y = get_elem(b, k * n, kk * n + j, w);
                    if (sgn && x >= (longint'(1) << (w - 1))) x -= longint'(1) << w;
                    if (sgn && y >= (longint'(1) << (w - 1))) y -= longint'(1) << w;
                    s += x * y;
                end
                r = put_elem(r, m * n, i * n + j, rw, s);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input bus_t act, input bus_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run0(input bus_t a, input bus_t b, output bus_t r, output int lat, output int bcnt);
        @(negedge clk);
        a0  = a[149:0];
        b0  = b[89:0];
        st0 = 1'b1;
        @(negedge clk);
        st0  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!fin0 && lat < 200) begin
            if (busy0) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = bus_t'(r0);
    endtask

    task automatic run1(input bus_t a, input bus_t b, output bus_t r, output int lat);
        @(negedge clk);
        a1  = a[31:0];
        b1  = b[31:0];
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        lat = 0;
        while (!fin1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = bus_t'(r1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t t0[8];
        vec_t t1[6];
        int   exp0[15] = '{9, 12, 15, 19, 26, 33, 29, 40, 51, 39, 54, 69, 49, 68, 87};
        bus_t res;
        int   lat;
        int   bcnt;

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        st0 = 1'b0;  st1 = 1'b0;  st2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

        // Default-instance table: two spec vectors, the rest random against the model
        t0[0].name = "plan_seq"; t0[0].a = '0; t0[0].b = '0; t0[0].r = '0;
        for (int e = 0; e < 10; e++) t0[0].a = put_elem(t0[0].a, 10, e, 15, longint'(e + 1));
        for (int e = 0; e < 6; e++)  t0[0].b = put_elem(t0[0].b, 6, e, 15, longint'(e + 1));
        for (int e = 0; e < 15; e++) t0[0].r = put_elem(t0[0].r, 15, e, 31, longint'(exp0[e]));
        t0[1].name = "plan_max"; t0[1].a = '0; t0[1].b = '0; t0[1].r = '0;
        for (int e = 0; e < 10; e++) t0[1].a = put_elem(t0[1].a, 10, e, 15, 32767);
        for (int e = 0; e < 6; e++)  t0[1].b = put_elem(t0[1].b, 6, e, 15, 32767);
        for (int e = 0; e < 15; e++) t0[1].r = put_elem(t0[1].r, 15, e, 31, 64'd2147352578);
        for (int v = 2; v < 8; v++) begin
            t0[v].name = $sformatf("rand0_%0d", v);
            t0[v].a = '0; t0[v].b = '0;
            for (int e = 0; e < 10; e++)
                t0[v].a = put_elem(t0[v].a, 10, e, 15,
                                   ($urandom_range(0, 3) == 0) ? 32767 : longint'($urandom & 32'h7fff));
            for (int e = 0; e < 6; e++)
                t0[v].b = put_elem(t0[v].b, 6, e, 15, longint'($urandom & 32'h7fff));
            t0[v].r = ref_mult(t0[v].a, t0[v].b, 5, 2, 3, 15, 31, 1'b0);
        end

        // Signed table: spec vector plus random with extremes mixed in
        t1[0].name = "plan_signed"; t1[0].a = '0; t1[0].b = '0; t1[0].r = '0;
        t1[0].a = put_elem(t1[0].a, 4, 0, 8, -1);   t1[0].a = put_elem(t1[0].a, 4, 1, 8, 2);
        t1[0].a = put_elem(t1[0].a, 4, 2, 8, 3);    t1[0].a = put_elem(t1[0].a, 4, 3, 8, -128);
        t1[0].b = put_elem(t1[0].b, 4, 0, 8, -128); t1[0].b = put_elem(t1[0].b, 4, 1, 8, 1);
        t1[0].b = put_elem(t1[0].b, 4, 2, 8, 1);    t1[0].b = put_elem(t1[0].b, 4, 3, 8, -1);
        t1[0].r = put_elem(t1[0].r, 4, 0, 17, 130); t1[0].r = put_elem(t1[0].r, 4, 1, 17, -3);
        t1[0].r = put_elem(t1[0].r, 4, 2, 17, -512); t1[0].r = put_elem(t1[0].r, 4, 3, 17, 131);
        for (int v = 1; v < 6; v++) begin
            t1[v].name = $sformatf("rand1_%0d", v);
            t1[v].a = '0; t1[v].b = '0;
            for (int e = 0; e < 4; e++) begin
                t1[v].a = put_elem(t1[v].a, 4, e, 8,
                                   ($urandom_range(0, 2) == 0) ? 128 : longint'($urandom & 32'hff));
                t1[v].b = put_elem(t1[v].b, 4, e, 8,
                                   ($urandom_range(0, 2) == 0) ? 128 : longint'($urandom & 32'hff));
            end
            t1[v].r = ref_mult(t1[v].a, t1[v].b, 2, 2, 2, 8, 17, 1'b1);
        end

        repeat (2) @(negedge clk);
        chk("reset_result", bus_t'(r0), '0);
        chk("reset_busy", bus_t'(busy0), '0);
        chk("reset_finished", bus_t'(fin0), '0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run0(t0[v].a, t0[v].b, res, lat, bcnt);
            chk({t0[v].name, "_result"}, res, t0[v].r);
            chk({t0[v].name, "_latency"}, bus_t'(lat), bus_t'(30));
            chk({t0[v].name, "_busy_cycles"}, bus_t'(bcnt), bus_t'(30));
            chk({t0[v].name, "_busy_low_at_done"}, bus_t'(busy0), '0);
        end

        // Start pulse and operand change during RUN must be ignored
        @(negedge clk);
        a0 = t0[0].a[149:0]; b0 = t0[0].b[89:0]; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (10) @(negedge clk);
        st0 = 1'b1; a0 = ~a0;
        @(negedge clk);
        st0 = 1'b0; a0 = t0[1].a[149:0];
        chk("midrun_start_busy", bus_t'(busy0), bus_t'(1));
        lat = 11;
        while (!fin0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("midrun_start_result", bus_t'(r0), t0[0].r);
        chk("midrun_start_latency", bus_t'(lat), bus_t'(30));

        // Reset mid-RUN discards everything, then a fresh run completes correctly
        @(negedge clk);
        a0 = t0[1].a[149:0]; b0 = t0[1].b[89:0]; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (15) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("midrun_reset_result", bus_t'(r0), '0);
        chk("midrun_reset_busy", bus_t'(busy0), '0);
        chk("midrun_reset_finished", bus_t'(fin0), '0);
        @(negedge clk);
        chk("midrun_reset_stays_idle", bus_t'(busy0), '0);
        run0(t0[2].a, t0[2].b, res, lat, bcnt);
        chk("after_reset_result", res, t0[2].r);
        chk("after_reset_latency", bus_t'(lat), bus_t'(30));

        for (int v = 0; v < 6; v++) begin
            run1(t1[v].a, t1[v].b, res, lat);
            chk({t1[v].name, "_result"}, res, t1[v].r);
            chk({t1[v].name, "_latency"}, bus_t'(lat), bus_t'(8));
        end

        // Reset and Start together: Reset wins, from DONE with a nonzero result
        @(negedge clk);
        rst1 = 1'b1; st1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0; st1 = 1'b0;
        chk("reset_start_busy", bus_t'(busy1), '0);
        chk("reset_start_finished", bus_t'(fin1), '0);
        chk("reset_start_result", bus_t'(r1), '0);

        // 1x1x1 with Start held: alternates RUN / DONE every cycle
        @(negedge clk);
        a2 = 15'd7; b2 = 15'd6; st2 = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk($sformatf("one_busy_%0d", n), bus_t'(busy2), bus_t'(n % 2));
            chk($sformatf("one_finished_%0d", n), bus_t'(fin2), bus_t'(1 - n % 2));
            if (n % 2 == 0) chk($sformatf("one_result_%0d", n), bus_t'(r2), bus_t'(42));
        end
        st2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
